pipe_fetch_stage: RTL and testbench
===================================

# pipe_fetch_stage

Fetch stage of the Y86-64 five-stage pipeline. It holds the F pipeline register (predicted PC) and selects the PC from the prediction, a mispredicted-branch redirect from M, or a return address from W. It reads and splits the instruction from an internal byte-addressed instruction memory, predicts the next PC, and loads the D pipeline register consumed by decode. Pipeline control drives its stall and bubble inputs.

## Interface
- `IMEM_BYTES`, 1024: instruction memory size in bytes.
- `RESET_PC`, 64'd0: F predicted-PC value after reset.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_we` in 1: instruction memory byte write enable.
- `imem_waddr` in 64: write byte address; ignored if ≥ IMEM_BYTES.
- `imem_wdata` in 8: write byte.
- `F_stall` in 1: hold the F register.
- `D_stall` in 1: hold the D register.
- `D_bubble` in 1: load a bubble into D.
- `M_icode` in 4, `M_cnd` in 1, `M_valA` in 64: memory-stage redirect inputs.
- `W_icode` in 4, `W_valM` in 64: writeback-stage ret inputs.
- `f_pc` out 64: selected fetch PC (combinational).
- `f_pred_pc` out 64: F register contents.
- `D_stat` out 3, `D_icode` out 4, `D_ifun` out 4, `D_rA` out 4, `D_rB` out 4, `D_valC` out 64, `D_valP` out 64: D register.

## Operation
- Status codes: AOK=1, HLT=2, ADR=3, INS=4.
- icodes: 0 halt, 1 nop, 2 rrmovq/cmov, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- PC select, in priority order:
  - M_icode==7 && !M_cnd → M_valA.
  - W_icode==9 → W_valM.
  - Otherwise f_pred_pc.
- Byte0 = {icode, ifun}.
- need_regids for icodes 2,3,4,5,6,A,B. When set, byte1 = {rA, rB}; otherwise rA = rB = 4'hF.
- need_valC for icodes 3,4,5,7,8. valC is 8 bytes little-endian, starting at byte1 for 7 and 8 and at byte2 for the others; otherwise valC = 0.
- valP = f_pc + 1 + need_regids + 8·need_valC, 64-bit wrap.
- Instruction is valid when icode ≤ B and ifun is in range:
  - icode 2 and 7: ifun 0–6.
  - icode 6: ifun 0–3.
  - All other icodes: ifun 0.
- imem_error when any byte in [f_pc, valP−1] is ≥ IMEM_BYTES. On error, icode and ifun are forced to 1 and 0.
- f_stat priority: imem_error→ADR, else invalid→INS, else icode 0→HLT, else AOK.
- Predicted PC = valC for icodes 7 and 8, else valP.
- Bubble value: stat AOK, icode 1, ifun 0, rA = rB = F, valC 0, valP 0.

## Timing
- Reset (asynchronous):
  - f_pred_pc = RESET_PC.
  - D register = bubble.
  - Instruction memory contents are not cleared.
- Reset asserted mid-operation clears F and D immediately, without waiting for a clock edge.
- Fetch path (PC select, memory read, split, align) is combinational from F and the M/W inputs. Results are latched at the next rising edge, so D has 1-cycle latency.
- F update: loads the predicted PC unless F_stall.
- D update:
  - D_bubble (priority) → bubble.
  - Else D_stall → hold.
  - Else load the fetched fields.
- F_stall with D_bubble is legal: F holds and D gets a bubble.
- Instruction memory write is synchronous. A same-cycle fetch of the written byte returns the old value.
- Redirect inputs override the prediction in the same cycle they are presented.

## Configuration
- `FETCH_HALT_LOCK_EN` defined:
  - A sticky lock sets at the edge where a non-AOK f_stat is loaded into D.
  - While locked, F holds and D loads bubbles every cycle.
  - The lock clears on reset or on either redirect condition, so a wrong-path halt is released.
- Not defined: no lock. Fetch continues at valP after HLT, INS or ADR, and downstream status handling stops the machine.

## Test plan
- irmovq: bytes 30 F0 10 00 00 00 00 00 00 00 at 0; release reset → D_icode=3, D_rA=F, D_rB=0, D_valC=0x10, D_valP=10, f_pred_pc=10.
- jmp prediction: bytes 70 40 00… at 0 → D_valC=0x40, D_valP=9, next f_pc=0x40. Then M_icode=7, M_cnd=0, M_valA=0x20 → f_pc=0x20 that cycle. Then W_icode=9, W_valM=0x30 → f_pc=0x30.
- Stall/bubble: F_stall=1 and D_stall=1 for 2 cycles → f_pred_pc and D unchanged. D_bubble=1 → D_icode=1, D_stat=1, D_rA=F.
- Errors:
  - Byte C0 → D_stat=4.
  - irmovq starting at IMEM_BYTES−5 → D_stat=3, D_icode=1.
  - Byte 00 → D_stat=2.
- Halt lock (macro on): halt at 8 → D_stat=2, then bubbles and f_pred_pc frozen at 9. M mispredict redirect to 0x20 → fetch resumes at 0x20. Macro off → fetch continues at 9.
- Async reset: drop rst_n between edges mid-program → f_pred_pc=RESET_PC and D=bubble immediately; first fetch after release comes from RESET_PC.

Source files
------------

// File: rtl/pipe_fetch_stage.sv
// Y86-64 pipeline fetch stage: F register (predicted PC), PC select,
// byte-addressed instruction memory, split/align, next-PC prediction and the
// D pipeline register.
// Optional feature macro: FETCH_HALT_LOCK_EN (sticky halt lock on non-AOK fetch).
module pipe_fetch_stage #(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] f_pc,
    output logic [63:0] f_pred_pc,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    localparam int unsigned AW      = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [63:0] MEM_TOP = 64'(IMEM_BYTES);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    logic [7:0]  imem [IMEM_BYTES];
    logic [7:0]  fbyte [10];
    logic        fbyte_ok [10];
    logic        m_mispredict, w_ret;
    logic [3:0]  imem_icode, imem_ifun, f_icode, f_ifun, f_ra, f_rb, f_len;
    logic        need_regids, need_valc, instr_valid, imem_error;
    logic [63:0] f_valc, f_valp, f_pred;
    logic [2:0]  f_stat;
    logic        lock_eff;

    // Synchronous byte write; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (imem_we && (imem_waddr < MEM_TOP))
            imem[AW'(imem_waddr)] <= imem_wdata;
    end

    // PC select: M mispredict beats W ret beats the prediction
    always_comb begin
        m_mispredict = (M_icode == I_JXX) && !M_cnd;
        w_ret        = (W_icode == I_RET);
        f_pc         = f_pred_pc;
        if (m_mispredict)
            f_pc = M_valA;
        else if (w_ret)
            f_pc = W_valM;
    end

    // Read the ten bytes an instruction can span; out-of-range bytes read as 0
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            fbyte_ok[k] = (f_pc + 64'(k)) < MEM_TOP;
            fbyte[k]    = 8'h00;
            if (fbyte_ok[k])
                fbyte[k] = imem[AW'(f_pc + 64'(k))];
        end
    end

    // Split, align, validate and predict
    always_comb begin
        imem_icode  = fbyte[0][7:4];
        imem_ifun   = fbyte[0][3:0];
        need_regids = imem_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        need_valc   = imem_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        f_len       = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
        f_valp      = f_pc + {60'd0, f_len};

        // Length comes from the raw opcode so a truncated instruction at the
        // top of memory is flagged as an address error.
        imem_error = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if ((k < int'(f_len)) && !fbyte_ok[k])
                imem_error = 1'b1;
        end

        f_ra = 4'hF;
        f_rb = 4'hF;
        if (need_regids)
            {f_ra, f_rb} = fbyte[1];

        f_valc = 64'd0;
        if (need_valc) begin
            for (int k = 0; k < 8; k++)
                f_valc[8*k +: 8] = ((imem_icode == I_JXX) || (imem_icode == I_CALL))
                                   ? fbyte[k+1] : fbyte[k+2];
        end

        case (imem_icode)
            4'h2, 4'h7: instr_valid = (imem_ifun <= 4'd6);
            4'h6:       instr_valid = (imem_ifun <= 4'd3);
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                        instr_valid = (imem_ifun == 4'd0);
            default:    instr_valid = 1'b0;
        endcase

        f_icode = imem_error ? I_NOP : imem_icode;
        f_ifun  = imem_error ? 4'h0  : imem_ifun;

        if (imem_error)              f_stat = STAT_ADR;
        else if (!instr_valid)       f_stat = STAT_INS;
        else if (f_icode == I_HALT)  f_stat = STAT_HLT;
        else                         f_stat = STAT_AOK;

        f_pred = ((f_icode == I_JXX) || (f_icode == I_CALL)) ? f_valc : f_valp;
    end

`ifdef FETCH_HALT_LOCK_EN
    logic lock;

    // Sticky lock once a non-AOK status enters D; any redirect releases it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock <= 1'b0;
        else
            lock <= lock_eff ||
                    (!D_bubble && !D_stall && !lock_eff && (f_stat != STAT_AOK));
    end

    assign lock_eff = lock && !(m_mispredict || w_ret);
`else
    assign lock_eff = 1'b0;
`endif

    // F register: predicted PC, held on stall or while locked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            f_pred_pc <= RESET_PC;
        else if (!F_stall && !lock_eff)
            f_pred_pc <= f_pred;
    end

    // D register: bubble has priority over stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || D_bubble || lock_eff) begin
            D_stat  <= STAT_AOK;
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= 4'hF;
            D_rB    <= 4'hF;
            D_valC  <= 64'd0;
            D_valP  <= 64'd0;
        end else if (!D_stall) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_ra;
            D_rB    <= f_rb;
            D_valC  <= f_valc;
            D_valP  <= f_valp;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
module tb_pipe_fetch_stage;

    localparam int unsigned NB = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] f_pc, f_pred_pc;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    pipe_fetch_stage #(.IMEM_BYTES(NB), .RESET_PC(64'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .f_pc(f_pc), .f_pred_pc(f_pred_pc),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    typedef struct packed {
        dreg_t       d;
        logic [63:0] pred;
    } fetch_t;

    localparam dreg_t BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                                 ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0};

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mdl [NB];
    logic [63:0] e_fpred;
    dreg_t       e_d;
    logic        e_lock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [63:0] a);
        return (a < 64'(NB)) ? mdl[a[9:0]] : 8'h00;
    endfunction

    // Reference decode: instruction length table drives everything else
    function automatic fetch_t model_fetch(input logic [63:0] pc);
        fetch_t      r;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [3:0]  ic, fn;
        int          len;
        bit          err, ok;
        logic [63:0] base;
        b0 = rd(pc);
        ic = b0[7:4];
        fn = b0[3:0];
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h3, 4'h4, 4'h5:       len = 10;
            4'h7, 4'h8:             len = 9;
            default:                len = 1;
        endcase
        err = 0;
        for (int i = 0; i < len; i++)
            if (pc + 64'(i) >= 64'(NB)) err = 1;
        if (ic == 4'h2 || ic == 4'h7) ok = (fn <= 6);
        else if (ic == 4'h6)          ok = (fn <= 3);
        else                          ok = (ic <= 4'hB) && (fn == 0);
        r.d.ra = 4'hF;
        r.d.rb = 4'hF;
        if (len == 2 || len == 10) begin
            b1 = rd(pc + 64'd1);
            r.d.ra = b1[7:4];
            r.d.rb = b1[3:0];
        end
        r.d.valc = 64'd0;
        if (len >= 9) begin
            base = (len == 9) ? pc + 64'd1 : pc + 64'd2;
            for (int i = 0; i < 8; i++)
                r.d.valc = r.d.valc | (64'(rd(base + 64'(i))) << (8 * i));
        end
        r.d.valp = pc + 64'(len);
        if (err) begin
            ic = 4'h1;
            fn = 4'h0;
        end
        r.d.icode = ic;
        r.d.ifun  = fn;
        r.d.stat  = err ? 3'd3 : !ok ? 3'd4 : (ic == 4'h0) ? 3'd2 : 3'd1;
        r.pred    = (ic == 4'h7 || ic == 4'h8) ? r.d.valc : r.d.valp;
        return r;
    endfunction

    task automatic model_reset();
        e_fpred = 64'd0;
        e_d     = BUBBLE;
        e_lock  = 1'b0;
    endtask

    task automatic chk_state();
        chk("f_pred_pc", f_pred_pc, e_fpred);
        chk("D_stat",  64'(D_stat),  64'(e_d.stat));
        chk("D_icode", 64'(D_icode), 64'(e_d.icode));
        chk("D_ifun",  64'(D_ifun),  64'(e_d.ifun));
        chk("D_rA",    64'(D_rA),    64'(e_d.ra));
        chk("D_rB",    64'(D_rB),    64'(e_d.rb));
        chk("D_valC",  D_valC, e_d.valc);
        chk("D_valP",  D_valP, e_d.valp);
    endtask

    // One clock with model prediction of combinational PC and next state
    task automatic step();
        fetch_t      f;
        logic [63:0] epc;
        bit          redir, lk, load, set_lock;
        #1;
        redir = (M_icode == 4'h7 && !M_cnd) || (W_icode == 4'h9);
        epc = (M_icode == 4'h7 && !M_cnd) ? M_valA : (W_icode == 4'h9) ? W_valM : e_fpred;
        chk("f_pc", f_pc, epc);
        f = model_fetch(epc);
`ifdef FETCH_HALT_LOCK_EN
        lk = e_lock && !redir;
`else
        lk = 0;
`endif
        load     = !D_bubble && !D_stall && !lk;
        set_lock = load && (f.d.stat != 3'd1);
        if (imem_we && imem_waddr < 64'(NB)) mdl[imem_waddr[9:0]] = imem_wdata;
        @(posedge clk);
        #1;
        if (!F_stall && !lk) e_fpred = f.pred;
        if (D_bubble || lk) e_d = BUBBLE;
        else if (!D_stall) e_d = f.d;
        e_lock = lk || set_lock;
        chk_state();
    endtask

    task automatic clear_redirect();
        M_icode = 4'h0; M_cnd = 1'b0; M_valA = 64'd0;
        W_icode = 4'h0; W_valM = 64'd0;
    endtask

    task automatic redirect_m(input logic [63:0] tgt);
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = tgt;
    endtask

    initial begin
        rst_n = 1'b0; imem_we = 1'b0; imem_waddr = 64'd0; imem_wdata = 8'h00;
        F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        clear_redirect();
        model_reset();

        // Program image: nops everywhere plus directed instructions
        for (int i = 0; i < NB; i++) mdl[i] = 8'h10;
        mdl[0] = 8'h30; mdl[1] = 8'hF0; mdl[2] = 8'h10;
        for (int i = 3; i < 10; i++) mdl[i] = 8'h00;
        mdl[10] = 8'h70; mdl[11] = 8'h40;
        for (int i = 12; i < 19; i++) mdl[i] = 8'h00;
        mdl[8'h50] = 8'hC0;
        mdl[8'h60] = 8'h00;
        mdl[8'h68] = 8'h00;
        mdl[NB-5] = 8'h30; mdl[NB-4] = 8'hF0;
        for (int i = NB - 3; i < NB; i++) mdl[i] = 8'h00;

        #1;
        for (int i = 0; i < NB; i++) begin
            imem_we = 1'b1; imem_waddr = 64'(i); imem_wdata = mdl[i];
            @(posedge clk);
            #1;
        end
        imem_we = 1'b0;

        // Reset state
        chk("rst_f_pred_pc", f_pred_pc, 64'd0);
        chk("rst_f_pc", f_pc, 64'd0);
        chk("rst_D_stat", 64'(D_stat), 64'd1);
        chk("rst_D_icode", 64'(D_icode), 64'd1);
        chk("rst_D_rA", 64'(D_rA), 64'hF);
        chk("rst_D_valP", D_valP, 64'd0);

        // irmovq at 0
        rst_n = 1'b1;
        step();
        chk("irm_icode", 64'(D_icode), 64'd3);
        chk("irm_rA", 64'(D_rA), 64'hF);
        chk("irm_rB", 64'(D_rB), 64'd0);
        chk("irm_valC", D_valC, 64'h10);
        chk("irm_valP", D_valP, 64'd10);
        chk("irm_pred", f_pred_pc, 64'd10);

        // jmp 0x40 at 10
        step();
        chk("jmp_icode", 64'(D_icode), 64'd7);
        chk("jmp_valC", D_valC, 64'h40);
        chk("jmp_valP", D_valP, 64'd19);
        chk("jmp_f_pc", f_pc, 64'h40);

        redirect_m(64'h20);
        #1 chk("mredir_f_pc", f_pc, 64'h20);
        step();
        clear_redirect();
        W_icode = 4'h9; W_valM = 64'h30;
        #1 chk("wret_f_pc", f_pc, 64'h30);
        step();
        W_icode = 4'h0;

        // Stall both registers for two cycles, then bubble
        F_stall = 1'b1; D_stall = 1'b1;
        step();
        step();
        chk("stall_pred", f_pred_pc, 64'h31);
        chk("stall_valP", D_valP, 64'h31);
        F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b1;
        step();
        chk("bub_icode", 64'(D_icode), 64'd1);
        chk("bub_stat", 64'(D_stat), 64'd1);
        chk("bub_rA", 64'(D_rA), 64'hF);
        chk("bub_valP", D_valP, 64'd0);
        D_bubble = 1'b0;

        // F_stall with D_bubble
        F_stall = 1'b1; D_bubble = 1'b1;
        step();
        chk("fsdb_pred", f_pred_pc, 64'h32);
        F_stall = 1'b0; D_bubble = 1'b0;

        // Error statuses
        redirect_m(64'h50);
        step();
        chk("ins_stat", 64'(D_stat), 64'd4);
        redirect_m(64'(NB - 5));
        step();
        chk("adr_stat", 64'(D_stat), 64'd3);
        chk("adr_icode", 64'(D_icode), 64'd1);
        redirect_m(64'h60);
        step();
        chk("hlt_stat", 64'(D_stat), 64'd2);
        chk("hlt_icode", 64'(D_icode), 64'd0);

        // Halt followed by free-running fetch or lock
        redirect_m(64'h68);
        step();
        chk("hl_stat", 64'(D_stat), 64'd2);
        chk("hl_pred", f_pred_pc, 64'h69);
        clear_redirect();
        step();
        step();
`ifdef FETCH_HALT_LOCK_EN
        chk("hl_frozen_pred", f_pred_pc, 64'h69);
        chk("hl_bubble_valP", D_valP, 64'd0);
`else
        chk("hl_cont_pred", f_pred_pc, 64'h6B);
        chk("hl_cont_valP", D_valP, 64'h6B);
`endif
        redirect_m(64'h20);
        step();
        chk("hl_release_valP", D_valP, 64'h21);
        chk("hl_release_pred", f_pred_pc, 64'h21);
        clear_redirect();
        step();

        // Asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_pred", f_pred_pc, 64'd0);
        chk("arst_icode", 64'(D_icode), 64'd1);
        chk("arst_stat", 64'(D_stat), 64'd1);
        chk("arst_rA", 64'(D_rA), 64'hF);
        chk("arst_valP", D_valP, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_refetch_icode", 64'(D_icode), 64'd3);
        chk("arst_refetch_pred", f_pred_pc, 64'd10);

        // Randomized traffic: stalls, bubbles, redirects, live memory writes
        for (int n = 0; n < 2500; n++) begin
            F_stall  = ($urandom_range(0, 7) == 0);
            D_stall  = ($urandom_range(0, 7) == 0);
            D_bubble = ($urandom_range(0, 9) == 0);
            M_icode  = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            M_cnd    = ($urandom_range(0, 1) == 1);
            M_valA   = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom}
                                                    : 64'($urandom_range(0, NB - 1));
            W_icode  = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
            W_valM   = ($urandom_range(0, 15) == 0) ? 64'($urandom_range(NB - 12, NB + 4))
                                                    : 64'($urandom_range(0, NB - 1));
            imem_we    = ($urandom_range(0, 1) == 1);
            imem_waddr = ($urandom_range(0, 31) == 0) ? 64'($urandom_range(NB, NB + 50))
                                                      : 64'($urandom_range(0, NB - 1));
            if ($urandom_range(0, 3) == 0) imem_waddr = f_pc;
            imem_wdata = 8'($urandom);
            step();
        end
        imem_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
